// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: state encoding, error codes,
// default header byte and the running-checksum helper.
package uart_pkg;

    localparam logic [2:0] ST_HUNT = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_GAP  = 2'd3;

    localparam logic [7:0] DEFAULT_HDR = 8'hAA;

    // Checksum is a plain modulo-256 sum of LEN and every payload byte.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_frame_parser_gap_timer.sv
// Inter-byte gap watchdog: counts idle cycles while enabled and flags expiry
// once GAP_CYC cycles pass without a clear.
module gap_timer #(
    parameter int GAP_CYC = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW    = $clog2(GAP_CYC + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(GAP_CYC);

    logic [CW-1:0] cnt_r;

    // Saturating idle counter; cleared by every consumed byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable && (cnt_r == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// Pulls bytes from a standard-read RX FIFO, validates HDR/LEN/payload/CSUM
// frames and replays accepted payloads on a valid/ready byte stream.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] HDR     = DEFAULT_HDR,
    parameter int         MAX_LEN = 16,
    parameter int         GAP_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       empty,
    output logic       rd_en,
    input  logic [7:0] dout,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic       rd_en_r;
    logic       pend_r;
    logic [7:0] len_r;
    logic [7:0] acc_r;
    logic [7:0] idx_r;
    logic [7:0] buf_r [MAX_LEN];
    logic [7:0] out_data_r;
    logic       out_valid_r;
    logic       out_last_r;
    logic       frame_ok_r;
    logic       frame_err_r;
    logic [1:0] err_code_r;

    logic       ok_s;
    logic       err_s;
    logic [1:0] code_s;
    logic       gap_active_s;
    logic       gap_clear_s;
    logic       timeout_s;
    logic       take_s;
    logic       last_s;

    assign gap_active_s = (state_r == ST_LEN) || (state_r == ST_DATA) || (state_r == ST_CSUM);
    assign gap_clear_s  = pend_r || !gap_active_s;
    // A timeout wins over a byte arriving in the same cycle; that byte is dropped.
    assign take_s       = pend_r && !timeout_s;
    assign last_s       = (idx_r == (len_r - 8'd1));

    gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (gap_clear_s),
        .enable  (gap_active_s),
        .expired (timeout_s)
    );

    // Next-state selection and frame verdict pulses.
    always_comb begin
        state_nxt_s = state_r;
        ok_s        = 1'b0;
        err_s       = 1'b0;
        code_s      = err_code_r;
        if (timeout_s) begin
            state_nxt_s = ST_HUNT;
            err_s       = 1'b1;
            code_s      = ERR_GAP;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    if (pend_r && (dout == HDR)) begin
                        state_nxt_s = ST_LEN;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_LEN: begin
                    if (pend_r) begin
                        if ((dout == 8'd0) || (dout > MAX_LEN_B)) begin
                            state_nxt_s = ST_HUNT;
                            err_s       = 1'b1;
                            code_s      = ERR_LEN;
                        end else begin
                            state_nxt_s = ST_DATA;
                        end
                    end else begin
                        state_nxt_s = ST_LEN;
                    end
                end
                ST_DATA: begin
                    if (pend_r && last_s) begin
                        state_nxt_s = ST_CSUM;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (pend_r) begin
                        if (dout == acc_r) begin
                            state_nxt_s = ST_SEND;
                            ok_s        = 1'b1;
                        end else begin
                            state_nxt_s = ST_HUNT;
                            err_s       = 1'b1;
                            code_s      = ERR_CSUM;
                        end
                    end else begin
                        state_nxt_s = ST_CSUM;
                    end
                end
                ST_SEND: begin
                    if (out_valid_r && out_ready && out_last_r) begin
                        state_nxt_s = ST_HUNT;
                    end else begin
                        state_nxt_s = ST_SEND;
                    end
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                end
            endcase
        end
    end

    // Payload storage; contents are only read after being written for the current frame.
    always_ff @(posedge clk) begin
        if ((state_r == ST_DATA) && take_s) begin
            buf_r[idx_r[IDX_W-1:0]] <= dout;
        end
    end

    // Control, FIFO read pacing, checksum datapath and output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HUNT;
            rd_en_r     <= 1'b0;
            pend_r      <= 1'b0;
            len_r       <= 8'd0;
            acc_r       <= 8'd0;
            idx_r       <= 8'd0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            err_code_r  <= ERR_NONE;
        end else begin
            state_r     <= state_nxt_s;
            frame_ok_r  <= ok_s;
            frame_err_r <= err_s;
            err_code_r  <= code_s;
            pend_r      <= rd_en_r;
            // One read in flight at a time; the FIFO flag seen here already reflects any previous pop.
            rd_en_r     <= !rd_en_r && !empty && (state_nxt_s != ST_SEND);
            case (state_r)
                ST_LEN: begin
                    if (take_s) begin
                        len_r <= dout;
                        acc_r <= dout;
                        idx_r <= 8'd0;
                    end
                end
                ST_DATA: begin
                    if (take_s) begin
                        acc_r <= csum_add(acc_r, dout);
                        idx_r <= idx_r + 8'd1;
                    end
                end
                ST_CSUM: begin
                    if (take_s) begin
                        idx_r <= 8'd0;
                    end
                end
                ST_SEND: begin
                    if (!out_valid_r || out_ready) begin
                        if (out_valid_r && out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end else begin
                            out_data_r  <= buf_r[idx_r[IDX_W-1:0]];
                            out_valid_r <= 1'b1;
                            out_last_r  <= last_s;
                            idx_r       <= idx_r + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_en     = rd_en_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign frame_ok  = frame_ok_r;
    assign frame_err = frame_err_r;
    assign err_code  = err_code_r;

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter HDR, default 8'hAA, frame header byte.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (1..255).
REQ-003 SHALL have parameter GAP_CYC, default 20000, maximum clk cycles between consecutive frame bytes.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port empty  input  1  RX FIFO empty flag.
REQ-007 SHALL have port rd_en  output  1  RX FIFO read strobe.
REQ-008 SHALL have port dout  input  8  RX FIFO data; valid the cycle after rd_en (standard, non-FWFT read).
REQ-009 SHALL have port out_data  output  8  payload byte.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_last  output  1  marks the final payload byte of a frame.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-015 SHALL have port err_code  output  2  1 = bad length, 2 = bad checksum, 3 = gap timeout; held until the next frame_err.

Function
REQ-016 Frame format SHALL be HDR, LEN, LEN payload bytes, CSUM, where CSUM = (LEN + sum of payload) mod 256.
REQ-017 SHALL implement the states HUNT, LEN, DATA, CSUM and SEND.
REQ-018 rd_en SHALL be asserted only when empty=0, state is not SEND, and no read issued in the previous cycle is still unconsumed; at most one read is outstanding at a time.
REQ-019 In HUNT, bytes not equal to HDR SHALL be discarded silently; HDR SHALL cause a move to LEN.
REQ-020 In LEN, a value of 0 or greater than MAX_LEN SHALL pulse frame_err with err_code=1 and return to HUNT; otherwise the value SHALL be latched, the checksum accumulator initialised to it, and the state moved to DATA.
REQ-021 In DATA, each byte SHALL be written to an internal MAX_LEN x 8 buffer at an incrementing index and added to the accumulator; after the LEN-th byte the state SHALL move to CSUM.
REQ-022 In CSUM, a match SHALL pulse frame_ok and move to SEND; a mismatch SHALL pulse frame_err with err_code=2 and return to HUNT, producing no payload output.
REQ-023 In SEND, the buffered bytes SHALL be presented in order.
REQ-024 In SEND, out_valid SHALL stay high and out_data SHALL stay stable until out_ready=1.
REQ-025 out_last SHALL be high with the LEN-th byte; its handshake SHALL return the block to HUNT.
REQ-026 The first payload byte SHALL appear on out_valid the cycle after the frame_ok pulse.
REQ-027 In LEN, DATA and CSUM, a gap counter SHALL be cleared on each consumed byte.
REQ-028 When the gap counter reaches GAP_CYC, the block SHALL pulse frame_err with err_code=3, drop any outstanding read data, and return to HUNT.
REQ-029 The gap counter SHALL be inactive in HUNT and SEND.
REQ-030 A byte of value HDR received inside LEN, DATA or CSUM SHALL be treated as data, not as a resynchronisation point.
REQ-031 frame_ok and frame_err SHALL never assert in the same cycle.

Reset
REQ-032 rst_n low SHALL force state=HUNT and clear rd_en, out_valid, out_last, frame_ok, frame_err, err_code, the gap counter, the buffer index and the accumulator to 0, immediately and independently of clk.
REQ-033 Reset mid-frame SHALL abandon the frame without any pulse.
REQ-034 A FIFO read in flight at reset SHALL be ignored.
REQ-035 Buffer contents SHALL need no reset.

Structure
REQ-036 The shared package uart_pkg SHALL hold the state encoding, the err_code constants and the default HDR.
REQ-037 The gap counter SHALL be a sub-module gap_timer (inputs clear and enable; output expired; parameter GAP_CYC).
REQ-038 The payload buffer SHALL be inferred as registers or distributed RAM, with no vendor primitive.

Verification
REQ-039 FIFO bytes AA 03 11 22 33 69 -> frame_ok pulse, then out_data 11, 22, 33 with out_last on 33, frame_err never asserted.
REQ-040 AA 03 11 22 33 68 -> frame_err with err_code=2, out_valid never asserted; a following good frame is output correctly.
REQ-041 55 00 AA 02 AA 01 AD -> leading 55 and 00 skipped; outputs AA, 01; frame_ok pulses once.
REQ-042 AA 00, then AA 11 (MAX_LEN=16) -> two frame_err pulses, each with err_code=1.
REQ-043 AA 02 10 followed by GAP_CYC idle cycles -> frame_err with err_code=3; a subsequent good frame is parsed.
REQ-044 A good frame with out_ready toggling 1-0-0-1 -> data held stable and no bytes lost or duplicated, rd_en stays low during SEND; rst_n pulsed mid-DATA -> all outputs 0 asynchronously, and the next frame parses cleanly.
